alu_regfile_datapath: RTL and testbench

- 8-bit execution datapath of the single-cycle processor: 8-entry x 8-bit register file plus a combinational ALU.
- ALU operand 1 is register-file read port 1.
- ALU operand 2 is supplied externally by the operand-select muxes (negated register value or immediate) outside this block.
- ALU result is written back to the register file on the clock edge when write is enabled.
- Control (register addresses, ALUOP, WRITEENABLE) comes from the instruction decoder.

---
 rtl/alu_regfile_datapath.sv | 67 ++++++
 tb/tb_alu_regfile_datapath.sv | 134 +++++++++++++
 2 files changed

// File: rtl/alu_regfile_datapath.sv
// Execution datapath of the single-cycle core: an 8 x 8-bit register file
// with two asynchronous read ports, and a combinational ALU whose result is
// written back into the register file.
module alu_regfile_datapath (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] WRITEREG,
  input  logic [2:0] READREG1,
  input  logic [2:0] READREG2,
  input  logic       WRITEENABLE,
  input  logic [2:0] ALUOP,
  input  logic [7:0] OPERAND2,
  output logic [7:0] OUT1,
  output logic [7:0] OUT2,
  output logic [7:0] ALURESULT
);

  localparam int DATA_W = 8;
  localparam int NUM_REGS = 8;

  typedef enum logic [2:0] {
    OP_FWD = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011
  } aluop_e;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             wr_sel;

  // Per-register write strobe. An unknown address or enable compares false,
  // so only a cleanly decoded register can ever be updated.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      wr_sel[i] = WRITEENABLE && (WRITEREG == 3'(i));
  end

  // Register file state: reset wins over any write at the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_sel[i]) regs[i] <= ALURESULT;
    end
  end

  // Asynchronous read ports; no write bypass, so a write shows up only
  // after the edge that stores it.
  assign OUT1 = regs[READREG1];
  assign OUT2 = regs[READREG2];

  // ALU: operand 1 is read port 1, operand 2 comes from the external muxes.
  // Subtraction is ADD with an already-negated operand 2.
  always_comb begin
    ALURESULT = '0;
    case (ALUOP)
      OP_FWD:  ALURESULT = OPERAND2;
      OP_ADD:  ALURESULT = OUT1 + OPERAND2;
      OP_AND:  ALURESULT = OUT1 & OPERAND2;
      OP_OR:   ALURESULT = OUT1 | OPERAND2;
      default: ALURESULT = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Directed bench for alu_regfile_datapath: hand-computed register contents
// and ALU results checked with immediate assertions.
module tb_alu_regfile_datapath;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [2:0] WRITEREG, READREG1, READREG2, ALUOP;
  logic       WRITEENABLE;
  logic [7:0] OPERAND2;
  logic [7:0] OUT1, OUT2, ALURESULT;

  int checks = 0;
  int errors = 0;
  logic [7:0] m [8];  // expected register contents, set by hand below

  alu_regfile_datapath dut (
    .CLK(CLK), .RESET(RESET), .WRITEREG(WRITEREG), .READREG1(READREG1),
    .READREG2(READREG2), .WRITEENABLE(WRITEENABLE), .ALUOP(ALUOP),
    .OPERAND2(OPERAND2), .OUT1(OUT1), .OUT2(OUT2), .ALURESULT(ALURESULT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one rising edge, then settle away from it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // read every register through both ports and compare to m[]
  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      READREG1 = 3'(i);
      READREG2 = 3'(7 - i);
      #1;
      chk($sformatf("%s_p1_r%0d", tag, i), OUT1, m[i]);
      chk($sformatf("%s_p2_r%0d", tag, 7 - i), OUT2, m[7 - i]);
    end
  endtask

  task automatic loadi(input logic [2:0] rd, input logic [7:0] v);
    ALUOP = 3'b000; OPERAND2 = v; WRITEREG = rd; WRITEENABLE = 1'b1;
    tick();
    WRITEENABLE = 1'b0;
    m[rd] = v;
  endtask

  initial begin
    RESET = 1'b1; WRITEENABLE = 1'b0; WRITEREG = 0; READREG1 = 0; READREG2 = 0;
    ALUOP = 0; OPERAND2 = 0;
    tick(); tick();
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    check_all("reset");

    // ALU sees 0x00 operand 1 after reset
    READREG1 = 3'd0; ALUOP = 3'b001; OPERAND2 = 8'h05; #1;
    chk("rst_add", ALURESULT, 8'h05);

    // loadi / forward
    loadi(3'd1, 8'h02);
    loadi(3'd2, 8'h03);
    READREG1 = 3'd1; READREG2 = 3'd2; #1;
    chk("loadi_r1", OUT1, 8'h02);
    chk("loadi_r2", OUT2, 8'h03);

    // add: r5 = r1 + 3
    READREG1 = 3'd1; OPERAND2 = 8'h03; ALUOP = 3'b001; WRITEREG = 3'd5; WRITEENABLE = 1'b1; #1;
    chk("add_comb", ALURESULT, 8'h05);
    tick(); m[5] = 8'h05;
    // sub: r4 = r1 + (-3)
    OPERAND2 = 8'hFD; WRITEREG = 3'd4; #1;
    chk("sub_comb", ALURESULT, 8'hFF);
    tick(); m[4] = 8'hFF;
    WRITEENABLE = 1'b0;
    // wrap: r7 = r4 + 1 (r7 preloaded nonzero so the 0x00 is a real write)
    loadi(3'd7, 8'h55);
    READREG1 = 3'd4; OPERAND2 = 8'h01; ALUOP = 3'b001; WRITEREG = 3'd7; WRITEENABLE = 1'b1; #1;
    chk("wrap_comb", ALURESULT, 8'h00);
    tick(); m[7] = 8'h00; WRITEENABLE = 1'b0;
    check_all("arith");

    // logic ops on r3 = 0x0C, result of AND stored into r0
    loadi(3'd3, 8'h0C);
    READREG1 = 3'd3; OPERAND2 = 8'h0A; ALUOP = 3'b010; #1;
    chk("and", ALURESULT, 8'h08);
    WRITEREG = 3'd0; WRITEENABLE = 1'b1;
    tick(); m[0] = 8'h08; WRITEENABLE = 1'b0;
    READREG1 = 3'd3; ALUOP = 3'b011; #1;
    chk("or", ALURESULT, 8'h0E);

    // reserved opcodes
    OPERAND2 = 8'hFF;
    for (int op = 4; op < 8; op++) begin
      ALUOP = 3'(op); #1;
      chk($sformatf("rsvd_%0d", op), ALURESULT, 8'h00);
    end

    // write disabled for several edges with a live result
    ALUOP = 3'b011; WRITEREG = 3'd3; WRITEENABLE = 1'b0;
    tick(); tick(); tick();
    check_all("we0");

    // read during write: no bypass
    loadi(3'd6, 8'h11);
    READREG1 = 3'd6; READREG2 = 3'd5; WRITEREG = 3'd6; ALUOP = 3'b000;
    OPERAND2 = 8'h22; WRITEENABLE = 1'b1; #1;
    chk("rdw_before", OUT1, 8'h11);
    tick();
    chk("rdw_after", OUT1, 8'h22);
    chk("rdw_other", OUT2, 8'h05);
    WRITEENABLE = 1'b0; m[6] = 8'h22;
    check_all("rdw");

    // reset with a concurrent write: reset wins
    RESET = 1'b1; WRITEENABLE = 1'b1; ALUOP = 3'b000; OPERAND2 = 8'h77; WRITEREG = 3'd2;
    tick();
    RESET = 1'b0; WRITEENABLE = 1'b0;
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    check_all("rst_we");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
